// File: rtl/card_deck_shuffler.sv
// rtl/card_deck_shuffler.sv - builds the 6x6 memory-card board and Fisher-Yates shuffles it.
// Define SHUFFLE_BYPASS_EN to skip the shuffle and leave the deck in fill order.
module card_deck_shuffler #(
  parameter int          NUM_CARDS = 36,
  parameter int          ADDR_W    = 6,
  parameter int          VAL_W     = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [VAL_W-1:0]  rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [ADDR_W-1:0]  r_idx;
  logic [VAL_W-1:0]   r_slot [NUM_CARDS];
  logic               r_busy;
  logic               r_done;
  logic               r_ready;
  logic [VAL_W-1:0]   r_rd_data;

  logic               w_fb;
  logic [VAL_W-1:0]   w_fill_val;
  logic               w_last_fill;
  logic               w_rd_in_range;

  assign busy    = r_busy;
  assign done    = r_done;
  assign ready   = r_ready;
  assign rd_data = r_rd_data;

  // Taps 16,14,13,11 expressed on a right-shifting register.
  assign w_fb          = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_fill_val    = VAL_W'(r_idx[ADDR_W-1:1]);
  assign w_last_fill   = (r_idx == ADDR_W'(NUM_CARDS - 1));
  assign w_rd_in_range = (32'(rd_addr) < NUM_CARDS);

`ifndef SHUFFLE_BYPASS_EN
  logic [ADDR_W-1:0]  w_mask;
  logic [ADDR_W-1:0]  w_r;
  logic               w_accept;

  // Draw range is the smallest all-ones mask covering i; draws above i are rejected.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if ((r_idx >> b) != '0) w_mask[b] = 1'b1;
    end
  end

  assign w_r      = r_lfsr[ADDR_W-1:0] & w_mask;
  assign w_accept = (w_r <= r_idx);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
      r_rd_data <= '0;
      for (int k = 0; k < NUM_CARDS; k++) r_slot[k] <= '0;
    end else begin
      r_lfsr    <= {w_fb, r_lfsr[15:1]};
      r_done    <= 1'b0;
      r_rd_data <= (r_ready && w_rd_in_range) ? r_slot[rd_addr] : '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_FILL: begin
          r_slot[r_idx] <= w_fill_val;
          if (w_last_fill) begin
`ifdef SHUFFLE_BYPASS_EN
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`else
            r_state <= S_SHUFFLE;
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
`ifndef SHUFFLE_BYPASS_EN
        S_SHUFFLE: begin
          if (w_accept) begin
            r_slot[r_idx] <= r_slot[w_r];
            r_slot[w_r]   <= r_slot[r_idx];
            if (r_idx == ADDR_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_deck_shuffler.sv
// tb/tb_card_deck_shuffler.sv - self-checking bench for card_deck_shuffler against a Fisher-Yates model.
module tb_card_deck_shuffler;

  localparam int          NUM_CARDS = 36;
  localparam int          ADDR_W    = 6;
  localparam int          VAL_W     = 5;
  localparam int          HMAX      = 8192;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              busy;
  logic              done;
  logic              ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [VAL_W-1:0]  rd_data;

  int          checks   = 0;
  int          errors   = 0;
  int          edge_cnt = 0;
  logic [15:0] m_lfsr   = SEED;
  logic [15:0] hist [HMAX];
  int          s_edge;
  int          exp_lat;
  int          exp_deck [NUM_CARDS];
  int          got_deck [NUM_CARDS];
  int          deck_a   [NUM_CARDS];

  card_deck_shuffler #(
    .NUM_CARDS(NUM_CARDS),
    .ADDR_W   (ADDR_W),
    .VAL_W    (VAL_W),
    .LFSR_SEED(SEED)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .ready  (ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  // hist[n] holds the generator value present just before the n-th edge since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt = 0;
      m_lfsr   = SEED;
    end else begin
      edge_cnt++;
      if (edge_cnt < HMAX) hist[edge_cnt] = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int mask_for(input int i);
    int m = 1;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  function automatic void build_model(input int s);
    int e, i, r, t;
    for (int k = 0; k < NUM_CARDS; k++) exp_deck[k] = k / 2;
`ifdef SHUFFLE_BYPASS_EN
    exp_lat = NUM_CARDS + 1;
`else
    e = s + NUM_CARDS + 1;
    i = NUM_CARDS - 1;
    while (i >= 1 && e < HMAX) begin
      r = (int'(hist[e]) % (2 ** ADDR_W)) & mask_for(i);
      if (r <= i) begin
        t           = exp_deck[i];
        exp_deck[i] = exp_deck[r];
        exp_deck[r] = t;
        i--;
      end
      e++;
    end
    exp_lat = e - s;
`endif
  endfunction

  task automatic read_slot(input int a, output int v);
    @(negedge clock);
    rd_addr = ADDR_W'(a);
    @(negedge clock);
    v = int'(rd_data);
  endtask

  task automatic sweep(input string tag, input bit zero);
    int v, a;
    int cnt [NUM_CARDS/2];
    for (int k = 0; k < NUM_CARDS / 2; k++) cnt[k] = 0;
    for (int x = 0; x < 2 ** ADDR_W; x++) begin
      read_slot(x, v);
      if (x < NUM_CARDS) begin
        got_deck[x] = v;
        check($sformatf("%s_slot%0d", tag, x), v, zero ? 0 : exp_deck[x]);
        if (v >= 0 && v < NUM_CARDS / 2) cnt[v]++;
      end else begin
        check($sformatf("%s_oob%0d", tag, x), v, 0);
      end
    end
    if (!zero) begin
      for (int k = 0; k < NUM_CARDS / 2; k++)
        check($sformatf("%s_hist%0d", tag, k), cnt[k], 2);
    end
    for (int n = 0; n < 12; n++) begin
      a = int'($urandom_range(0, 2 ** ADDR_W - 1));
      read_slot(a, v);
      check($sformatf("%s_rand%0d", tag, a), v, (zero || a >= NUM_CARDS) ? 0 : exp_deck[a]);
    end
  endtask

  task automatic start_game();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    s_edge = edge_cnt;
    @(negedge clock);
    start = 1'b0;
    check("start_ready_low", int'(ready), 0);
    check("start_busy_high", int'(busy), 1);
  endtask

  task automatic wait_done(input bit extra);
    int busy_bad = 0;
    int lat      = -1;
    int pulses   = 0;
    for (int c = 1; c < 3000; c++) begin
      if (done) begin
        lat = edge_cnt - s_edge + 1;
        break;
      end
      if (!busy) busy_bad++;
      if (extra) start = (c == 5 || c == 20 || c == 40);
      @(negedge clock);
    end
    start = 1'b0;
    build_model(s_edge);
    check("done_latency", lat, exp_lat);
    check("busy_held", busy_bad, 0);
    @(negedge clock);
    check("done_one_cycle", int'(done), 0);
    check("ready_after", int'(ready), 1);
    check("busy_after", int'(busy), 0);
    if (extra) begin
      for (int c = 0; c < 60; c++) begin
        if (done) pulses++;
        @(negedge clock);
      end
      check("extra_done_pulses", pulses, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic int diff_from_fill();
    int n = 0;
    for (int k = 0; k < NUM_CARDS; k++) if (got_deck[k] != k / 2) n++;
    return n;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    repeat (10) @(negedge clock);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(ready), 0);
    check("idle_done", int'(done), 0);
    check("idle_rd_data", int'(rd_data), 0);
    sweep("idle", 1'b1);

    repeat ($urandom_range(5, 60)) @(negedge clock);
    start_game();
    wait_done(1'b0);
    sweep("g1", 1'b0);
`ifdef SHUFFLE_BYPASS_EN
    check("g1_fill_order", diff_from_fill(), 0);
`else
    check("g1_shuffled", int'(diff_from_fill() != 0), 1);
`endif

    repeat ($urandom_range(1, 30)) @(negedge clock);
    start_game();
    wait_done(1'b1);
    sweep("g2", 1'b0);

    start_game();
`ifdef SHUFFLE_BYPASS_EN
    repeat (20) @(negedge clock);
`else
    repeat (50) @(negedge clock);
`endif
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(ready), 0);
    check("abort_done", int'(done), 0);
    check("abort_rd_data", int'(rd_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) n++;
      @(negedge clock);
    end
    check("abort_no_done", n, 0);
    check("abort_ready_idle", int'(ready), 0);
    start_game();
    wait_done(1'b0);
    sweep("g3", 1'b0);

    do_reset();
    repeat (99) @(negedge clock);
    start_game();
    wait_done(1'b0);
    sweep("ga", 1'b0);
    for (int k = 0; k < NUM_CARDS; k++) deck_a[k] = got_deck[k];

    do_reset();
    repeat (136) @(negedge clock);
    start_game();
    wait_done(1'b0);
    sweep("gb", 1'b0);
    n = 0;
    for (int k = 0; k < NUM_CARDS; k++) if (deck_a[k] != got_deck[k]) n++;
`ifdef SHUFFLE_BYPASS_EN
    check("decks_same_bypass", n, 0);
`else
    check("decks_differ", int'(n != 0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
